// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from the core, imem address/data, and the decode-facing
// instruction word. The master side is the fetch unit itself.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 9
);
   logic                  start;
   logic                  stall;
   logic                  branch_taken;
   logic [ADDR_WIDTH-1:0] branch_target;
   logic [ADDR_WIDTH-1:0] instr_addr;
   logic [DATA_WIDTH-1:0] imem_instr;
   logic [DATA_WIDTH-1:0] instr_out;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  done;

   modport master (
      input  start, stall, branch_taken, branch_target, imem_instr,
      output instr_addr, instr_out, instr_pc, instr_valid, done
   );

   modport slave (
      output start, stall, branch_taken, branch_target, imem_instr,
      input  instr_addr, instr_out, instr_pc, instr_valid, done
   );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives the imem address from the PC and registers
// the returned word for decode, with start/stall/branch-squash/halt control.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 9,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
   parameter logic [DATA_WIDTH-1:0] HALT_INSTR = {DATA_WIDTH{1'b1}}
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_p0, pc_d;
   logic [DATA_WIDTH-1:0] instr_p1, instr_d;
   logic [ADDR_WIDTH-1:0] ipc_p1, ipc_d;
   logic                  vld_p1, vld_d;
   logic                  done_q, done_d;
   logic                  halt_seen;

   function automatic logic [ADDR_WIDTH-1:0] pc_incr(input logic [ADDR_WIDTH-1:0] pc);
      return pc + ADDR_WIDTH'(1);
   endfunction

   assign halt_seen = vld_p1 && (instr_p1 == HALT_INSTR);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_p0;
      instr_d = instr_p1;
      ipc_d   = ipc_p1;
      vld_d   = vld_p1;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            vld_d = 1'b0;
            if (bus.start) begin
               state_d = S_RUN;
               pc_d    = START_ADDR;
            end
         end
         S_RUN: begin
            if (bus.start) begin
               pc_d  = START_ADDR;
               vld_d = 1'b0;
            end else if (bus.stall) begin
               // whole stage frozen; a branch seen here must be re-presented later
            end else if (halt_seen) begin
               state_d = S_HALT;
               done_d  = 1'b1;
               vld_d   = 1'b0;
            end else if (vld_p1 && bus.branch_taken) begin
               // the word fetched this cycle is wrong-path: drop it, one bubble
               pc_d  = bus.branch_target;
               vld_d = 1'b0;
            end else begin
               instr_d = bus.imem_instr;
               ipc_d   = pc_p0;
               vld_d   = 1'b1;
               pc_d    = pc_incr(pc_p0);
            end
         end
         S_HALT: begin
            done_d = 1'b1;
            vld_d  = 1'b0;
            if (bus.start) begin
               state_d = S_RUN;
               pc_d    = START_ADDR;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = START_ADDR;
            vld_d   = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // stage 0 -> stage 1: PC register and instruction register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_p0    <= START_ADDR;
         instr_p1 <= '0;
         ipc_p1   <= '0;
         vld_p1   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_p0    <= pc_d;
         instr_p1 <= instr_d;
         ipc_p1   <= ipc_d;
         vld_p1   <= vld_d;
         done_q   <= done_d;
      end
   end

   assign bus.instr_addr  = pc_p0;
   assign bus.instr_out   = instr_p1;
   assign bus.instr_pc    = ipc_p1;
   assign bus.instr_valid = vld_p1;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected (pc, instr) pairs is
// consumed whenever decode would accept a valid word; control timing is checked inline.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_unit_if a ();
   fetch_unit_if b ();

   logic [8:0] mem [1024];
   assign a.imem_instr = mem[a.instr_addr];
   assign b.imem_instr = mem[b.instr_addr];

   fetch_unit u_a (.clk(clk), .rst_n(rst_n), .bus(a.master));
   fetch_unit #(.START_ADDR(10'd1023)) u_b (.clk(clk), .rst_n(rst_n), .bus(b.master));

   typedef struct packed {
      logic [9:0] pc;
      logic [8:0] ins;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t       e;
         logic [9:0] p;
         p     = 10'(lo + i);
         e.pc  = p;
         e.ins = mem[p];
         exp_q.push_back(e);
      end
   endtask

   task automatic start_a();
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
   endtask

   task automatic wait_a_pc(input int pc, input string tag);
      int k = 0;
      while (!(a.instr_valid === 1'b1 && a.instr_pc === 10'(pc)) && k < 60) begin
         tick();
         k++;
      end
      chk(tag, 32'(k < 60), 32'd1);
   endtask

   task automatic wait_a_done(input string tag);
      int k = 0;
      while (a.done !== 1'b1 && k < 60) begin
         tick();
         k++;
      end
      chk(tag, 32'(k < 60), 32'd1);
   endtask

   // decode accepts a word on any edge where it is valid and not held/restarted
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && a.instr_valid === 1'b1 && a.stall === 1'b0 && a.start === 1'b0) begin
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL sb_unexpected observed pc=%0h instr=%0h expected=none", a.instr_pc, a.instr_out);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", 32'(a.instr_pc), 32'(e.pc));
            chk("sb_instr", 32'(a.instr_out), 32'(e.ins));
         end
      end
   end

   initial begin
      int k;
      for (int i = 0; i < 1024; i++) mem[i] = 9'(i & 255);
      mem[8]      = 9'h1FF;
      mem[10'h302] = 9'h1FF;

      a.start = 1'b0; a.stall = 1'b0; a.branch_taken = 1'b0; a.branch_target = '0;
      b.start = 1'b0; b.stall = 1'b0; b.branch_taken = 1'b0; b.branch_target = '0;
      rst_n = 1'b0;
      repeat (3) tick();

      // reset values
      chk("rst_valid", 32'(a.instr_valid), 32'd0);
      chk("rst_done", 32'(a.done), 32'd0);
      chk("rst_addr", 32'(a.instr_addr), 32'd0);
      chk("rst_out", 32'(a.instr_out), 32'd0);
      chk("rst_ipc", 32'(a.instr_pc), 32'd0);
      chk("rst_b_addr", 32'(b.instr_addr), 32'd1023);
      chk("rst_b_valid", 32'(b.instr_valid), 32'd0);

      rst_n = 1'b1;
      a.branch_taken = 1'b1; a.branch_target = 10'h55;
      tick();
      a.branch_taken = 1'b0;
      tick();
      chk("idle_valid", 32'(a.instr_valid), 32'd0);
      chk("idle_addr", 32'(a.instr_addr), 32'd0);

      // PC wrap from 1023
      b.start = 1'b1;
      tick();
      b.start = 1'b0;
      chk("wrap_start_addr", 32'(b.instr_addr), 32'd1023);
      chk("wrap_start_valid", 32'(b.instr_valid), 32'd0);
      tick();
      chk("wrap_v0", 32'(b.instr_valid), 32'd1);
      chk("wrap_pc0", 32'(b.instr_pc), 32'd1023);
      chk("wrap_ins0", 32'(b.instr_out), 32'h0FF);
      chk("wrap_addr0", 32'(b.instr_addr), 32'd0);
      tick();
      chk("wrap_pc1", 32'(b.instr_pc), 32'd0);
      chk("wrap_ins1", 32'(b.instr_out), 32'd0);
      tick();
      chk("wrap_pc2", 32'(b.instr_pc), 32'd1);
      k = 0;
      while (b.done !== 1'b1 && k < 60) begin tick(); k++; end
      chk("wrap_done", 32'(k < 60), 32'd1);
      chk("wrap_halt_addr", 32'(b.instr_addr), 32'd9);
      chk("a_still_idle", 32'(a.instr_valid), 32'd0);

      // straight-line run to HALT
      push_run(0, 9);
      start_a();
      chk("run_start_addr", 32'(a.instr_addr), 32'd0);
      chk("run_start_valid", 32'(a.instr_valid), 32'd0);
      wait_a_done("run_done");
      chk("run_halt_valid", 32'(a.instr_valid), 32'd0);
      chk("run_halt_addr", 32'(a.instr_addr), 32'd9);
      chk("run_sb_empty", 32'(exp_q.size()), 32'd0);
      a.branch_taken = 1'b1; a.branch_target = 10'h55;
      repeat (2) tick();
      a.branch_taken = 1'b0;
      chk("halt_sticky", 32'(a.done), 32'd1);
      chk("halt_no_redirect", 32'(a.instr_addr), 32'd9);

      // stall held three cycles at instr_pc 3
      push_run(0, 9);
      start_a();
      chk("restart_done_clr", 32'(a.done), 32'd0);
      wait_a_pc(3, "stall_reach3");
      a.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ipc", 32'(a.instr_pc), 32'd3);
         chk("stall_out", 32'(a.instr_out), 32'd3);
         chk("stall_addr", 32'(a.instr_addr), 32'd4);
         chk("stall_valid", 32'(a.instr_valid), 32'd1);
      end
      a.stall = 1'b0;
      wait_a_done("stall_done");
      chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

      // branch squash, stall+branch, halt+branch
      push_run(0, 6);
      push_run('h100, 2);
      push_run('h300, 3);
      start_a();
      wait_a_pc(5, "br_reach5");
      a.branch_taken = 1'b1; a.branch_target = 10'h100;
      tick();
      a.branch_taken = 1'b0;
      chk("br_bubble", 32'(a.instr_valid), 32'd0);
      chk("br_addr", 32'(a.instr_addr), 32'h100);
      tick();
      chk("br_tgt_valid", 32'(a.instr_valid), 32'd1);
      chk("br_tgt_pc", 32'(a.instr_pc), 32'h100);
      tick();
      chk("br_next_pc", 32'(a.instr_pc), 32'h101);
      a.stall = 1'b1; a.branch_taken = 1'b1; a.branch_target = 10'h300;
      tick();
      chk("stbr_ipc", 32'(a.instr_pc), 32'h101);
      chk("stbr_addr", 32'(a.instr_addr), 32'h102);
      chk("stbr_valid", 32'(a.instr_valid), 32'd1);
      a.stall = 1'b0;
      tick();
      a.branch_taken = 1'b0;
      chk("stbr_bubble", 32'(a.instr_valid), 32'd0);
      chk("stbr_addr2", 32'(a.instr_addr), 32'h300);
      tick();
      chk("stbr_tgt_pc", 32'(a.instr_pc), 32'h300);
      wait_a_pc('h302, "hb_reach");
      a.branch_taken = 1'b1; a.branch_target = 10'h050;
      tick();
      a.branch_taken = 1'b0;
      chk("hb_done", 32'(a.done), 32'd1);
      chk("hb_valid", 32'(a.instr_valid), 32'd0);
      chk("hb_addr", 32'(a.instr_addr), 32'h303);
      tick();
      chk("hb_addr_hold", 32'(a.instr_addr), 32'h303);
      chk("br_sb_empty", 32'(exp_q.size()), 32'd0);

      // restart in RUN, then reset mid-run
      push_run(0, 2);
      start_a();
      chk("r6_done_clr", 32'(a.done), 32'd0);
      wait_a_pc(2, "r6_reach2");
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
      chk("r6_restart_valid", 32'(a.instr_valid), 32'd0);
      chk("r6_restart_addr", 32'(a.instr_addr), 32'd0);
      push_run(0, 3);
      wait_a_pc(3, "r6_reach3");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", 32'(a.instr_valid), 32'd0);
      chk("mid_rst_done", 32'(a.done), 32'd0);
      chk("mid_rst_addr", 32'(a.instr_addr), 32'd0);
      chk("mid_rst_out", 32'(a.instr_out), 32'd0);
      chk("mid_rst_ipc", 32'(a.instr_pc), 32'd0);
      chk("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) tick();
      chk("post_rst_idle", 32'(a.instr_valid), 32'd0);
      push_run(0, 9);
      start_a();
      wait_a_done("final_done");
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
